line_window_gen: RTL and testbench

- Raster-scan pixel-stream consumer that owns two line_buffer-style single-port RAMs (read-first) and produces a 3x3 sliding window per pixel.
- Sits downstream of the pixel source and upstream of 3x3 kernels (conv/filter) in the image pipeline.
- Valid/ready on both sides; windows emitted only where fully inside the frame (no padding).

---
 rtl/line_window_gen.sv | 147 ++++++++++++++
 tb/tb_line_window_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// Raster-scan 3x3 window generator: two read-first line RAMs feed a 3x3 register window.
// Optional LINE_WINDOW_SOF_EN adds in_sof to force the accepted pixel to position (0,0).
module line_window_gen #(
  parameter int data_width = 8,
  parameter int addr_width = 7,
  parameter int img_width  = 128,
  parameter int img_height = 128
) (
  input  logic                          clka,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [data_width-1:0]         in_data,
`ifdef LINE_WINDOW_SOF_EN
  input  logic                          in_sof,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [9*data_width-1:0]       out_win,
  output logic [$clog2(img_height)-1:0] out_row,
  output logic [addr_width-1:0]         out_col,
  output logic                          frame_done
);
  localparam int RW = $clog2(img_height);
  localparam logic [addr_width-1:0] COL_LAST = addr_width'(img_width - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(img_height - 1);

  logic adv, accept, sof;
  logic [addr_width-1:0] col_q, col_d, pos_col;
  logic [RW-1:0]         row_q, row_d, pos_row;
  logic                  fd_q, fd_d;

  logic                  s1_vld_q, s1_vld_d;
  logic [data_width-1:0] s1_pix_q, s1_pix_d;
  logic [addr_width-1:0] s1_col_q, s1_col_d;
  logic [RW-1:0]         s1_row_q, s1_row_d;

  logic [2:0][2:0][data_width-1:0] win_q, win_d;
  logic                  ov_q, ov_d;
  logic [RW-1:0]         orow_q, orow_d;
  logic [addr_width-1:0] ocol_q, ocol_d;

  logic [data_width-1:0] lb0_mem [2**addr_width];
  logic [data_width-1:0] lb1_mem [2**addr_width];
  logic [data_width-1:0] lb0_rd_q, lb1_rd_q;

  assign adv      = !ov_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
`ifdef LINE_WINDOW_SOF_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  always_comb begin
    pos_col = sof ? '0 : col_q;
    pos_row = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    fd_d    = accept && (pos_col == COL_LAST) && (pos_row == ROW_LAST);
    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + addr_width'(1);
        row_d = pos_row;
      end
    end
  end

  always_comb begin
    s1_vld_d = adv ? accept : s1_vld_q;
    s1_pix_d = accept ? in_data : s1_pix_q;
    s1_col_d = accept ? pos_col : s1_col_q;
    s1_row_d = accept ? pos_row : s1_row_q;
  end

  // New column enters on the right: oldest line (lb1) on top, current pixel at the bottom.
  always_comb begin
    win_d  = win_q;
    ov_d   = ov_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    if (adv) begin
      if (s1_vld_q) begin
        for (int i = 0; i < 3; i++) begin
          win_d[i][0] = win_q[i][1];
          win_d[i][1] = win_q[i][2];
        end
        win_d[0][2] = lb1_rd_q;
        win_d[1][2] = lb0_rd_q;
        win_d[2][2] = s1_pix_q;
        ov_d   = (s1_row_q >= RW'(2)) && (s1_col_q >= addr_width'(2));
        orow_d = s1_row_q - RW'(1);
        ocol_d = s1_col_q - addr_width'(1);
      end else begin
        ov_d = 1'b0;
      end
    end
  end

  // Line RAMs are not reset; rows 0/1 gating masks any stale contents.
  always_ff @(posedge clka) begin
    if (accept) begin
      lb0_rd_q         <= lb0_mem[pos_col];
      lb1_rd_q         <= lb1_mem[pos_col];
      lb0_mem[pos_col] <= in_data;
      lb1_mem[pos_col] <= lb0_mem[pos_col];
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      fd_q     <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_pix_q <= '0;
      s1_col_q <= '0;
      s1_row_q <= '0;
      win_q    <= '0;
      ov_q     <= 1'b0;
      orow_q   <= '0;
      ocol_q   <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      fd_q     <= fd_d;
      s1_vld_q <= s1_vld_d;
      s1_pix_q <= s1_pix_d;
      s1_col_q <= s1_col_d;
      s1_row_q <= s1_row_d;
      win_q    <= win_d;
      ov_q     <= ov_d;
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_win    = win_q;
  assign out_row    = orow_q;
  assign out_col    = ocol_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen: a 4x4 instance for directed frames and a
// 128x128 instance for a random-gap frame, both checked against a frame-image model.
module tb_line_window_gen;
  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic       rst_n, in_valid, out_ready, sel;
  logic [7:0] in_data;
`ifdef LINE_WINDOW_SOF_EN
  logic       in_sof;
`endif

  logic        s_in_ready, s_out_valid, s_fd;
  logic [71:0] s_out_win;
  logic [1:0]  s_out_row, s_out_col;
  logic        b_in_ready, b_out_valid, b_fd;
  logic [71:0] b_out_win;
  logic [6:0]  b_out_row, b_out_col;

  line_window_gen #(.data_width(8), .addr_width(2), .img_width(4), .img_height(4)) u_small (
    .clka(clka), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(s_in_ready),
    .in_data(in_data),
`ifdef LINE_WINDOW_SOF_EN
    .in_sof(in_sof),
`endif
    .out_valid(s_out_valid), .out_ready(out_ready), .out_win(s_out_win),
    .out_row(s_out_row), .out_col(s_out_col), .frame_done(s_fd));

  line_window_gen u_big (
    .clka(clka), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .in_data(in_data),
`ifdef LINE_WINDOW_SOF_EN
    .in_sof(in_sof),
`endif
    .out_valid(b_out_valid), .out_ready(out_ready), .out_win(b_out_win),
    .out_row(b_out_row), .out_col(b_out_col), .frame_done(b_fd));

  logic        mo_valid, mo_fd, in_rdy;
  logic [71:0] mo_win;
  logic [7:0]  mo_row, mo_col;
  assign mo_valid = sel ? b_out_valid : s_out_valid;
  assign mo_fd    = sel ? b_fd : s_fd;
  assign in_rdy   = sel ? b_in_ready : s_in_ready;
  assign mo_win   = sel ? b_out_win : s_out_win;
  assign mo_row   = sel ? 8'(b_out_row) : 8'(s_out_row);
  assign mo_col   = sel ? 8'(b_out_col) : 8'(s_out_col);

  typedef struct { logic [71:0] win; int row; int col; int cyc; } exp_t;
  exp_t q[$];
  logic [7:0]  img [128][128];
  int mr = 0, mc = 0, mw = 4, mh = 4;
  int total = 0, bad = 0, cyc = 0, rx_cnt = 0, fd_cnt = 0;
  int ordy_mode = 0, gap_pct = 0;
  bit lat_chk = 1'b1;
  logic [71:0] first_win, last_win;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: remember every pixel of the frame; a window centred at (r-1,c-1) is due
  // whenever pixel (r,c) with r,c >= 2 is accepted.
  task automatic model_accept(input logic [7:0] d, input bit sof);
    exp_t e;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = d;
    if (mr >= 2 && mc >= 2) begin
      e.win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[(3*i+j)*8 +: 8] = img[mr-2+i][mc-2+j];
      e.row = mr - 1;
      e.col = mc - 1;
      e.cyc = cyc + 2;
      q.push_back(e);
    end
    if (mc == mw - 1) begin
      mc = 0;
      mr = (mr == mh - 1) ? 0 : mr + 1;
    end else mc++;
  endtask

  task automatic send(input logic [7:0] d, input bit sof);
    int n = 0;
    bit pres = 1'b0;
    while (1) begin
      @(posedge clka); #2;
      if (!pres) begin
        if ($urandom_range(99) < gap_pct) begin
          in_valid = 1'b0;
          continue;
        end
        pres = 1'b1;
        in_valid = 1'b1;
        in_data = d;
`ifdef LINE_WINDOW_SOF_EN
        in_sof = sof;
`endif
      end
      if (in_rdy) begin
        model_accept(d, sof);
        break;
      end
      n++;
      if (n > 1000) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready stuck low, want high within 1000 cycles");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clka); #2; in_valid = 1'b0; end
  endtask

  task automatic drain();
    int k = 0;
    idle(2);
    while (q.size() != 0 && k < 200) begin @(posedge clka); k++; end
    chk("drain_pending", q.size(), 0);
    idle(3);
  endtask

  task automatic start_test(input bit s, input int w, input int h, input int om, input bit lc,
                            input int gp);
    sel = s; mw = w; mh = h; ordy_mode = om; lat_chk = lc; gap_pct = gp;
    rx_cnt = 0; fd_cnt = 0;
    idle(2);
  endtask

  task automatic end_test(input string nm, input int nwin, input int nfd);
    drain();
    chk({nm, "_windows"}, rx_cnt, nwin);
    chk({nm, "_frame_done"}, fd_cnt, nfd);
  endtask

  initial forever begin
    @(posedge clka); #1;
    case (ordy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(1));
    endcase
  end

  // Monitor: pops one expectation per transfer and checks hold behaviour under backpressure.
  initial begin
    exp_t e;
    bit held = 1'b0;
    logic [71:0] held_win = '0;
    forever begin
      @(negedge clka);
      if (!rst_n) begin held = 1'b0; continue; end
      if (mo_fd) fd_cnt++;
      if (mo_valid) begin
        if (held) chk("hold_stable", mo_win, held_win);
        if (out_ready) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_window: got row %0d col %0d, want none", mo_row, mo_col);
          end else begin
            e = q.pop_front();
            chk("win", mo_win, e.win);
            chk("row", mo_row, e.row);
            chk("col", mo_col, e.col);
            if (lat_chk) chk("latency", cyc, e.cyc);
          end
          if (rx_cnt == 0) first_win = mo_win;
          last_win = mo_win;
          rx_cnt++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_win = mo_win;
          chk("in_ready_stall", in_rdy, 0);
        end
      end else held = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 1'b0;
`ifdef LINE_WINDOW_SOF_EN
    in_sof = 1'b0;
`endif
    repeat (3) @(posedge clka);
    #2;
    chk("rst_out_valid", mo_valid, 0);
    chk("rst_out_win", mo_win, 0);
    chk("rst_out_row", mo_row, 0);
    chk("rst_out_col", mo_col, 0);
    chk("rst_frame_done", mo_fd, 0);
    chk("rst_in_ready", in_rdy, 1);
    rst_n = 1'b1;

    // 4x4 frame, full throughput
    start_test(1'b0, 4, 4, 0, 1'b1, 0);
    for (int p = 0; p < 16; p++) send(8'(p), 1'b0);
    end_test("t1", 4, 1);
    chk("t1_first_win", first_win, 72'h0a0908060504020100);
    chk("t1_last_win", last_win, 72'h0f0e0d0b0a09070605);

    // same frame, out_ready toggling
    start_test(1'b0, 4, 4, 1, 1'b0, 0);
    for (int p = 0; p < 16; p++) send(8'(p), 1'b0);
    end_test("t2", 4, 1);

    // two back-to-back frames, second offset by 100
    start_test(1'b0, 4, 4, 0, 1'b1, 0);
    for (int p = 0; p < 16; p++) send(8'(p), 1'b0);
    for (int p = 0; p < 16; p++) send(8'(p + 100), 1'b0);
    end_test("t3", 8, 2);
    chk("t3_second_first_win", first_win == last_win, 0);

    // reset mid-frame after 7 pixels, then a fresh frame
    start_test(1'b0, 4, 4, 0, 1'b1, 0);
    for (int p = 0; p < 7; p++) send(8'(p + 30), 1'b0);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", mo_valid, 0);
    chk("midrst_frame_done", mo_fd, 0);
    idle(3);
    mr = 0; mc = 0;
    rst_n = 1'b1;
    for (int p = 0; p < 16; p++) send(8'(p + 50), 1'b0);
    end_test("t4", 4, 1);

`ifdef LINE_WINDOW_SOF_EN
    // in_sof on the 6th pixel restarts the frame
    start_test(1'b0, 4, 4, 0, 1'b1, 0);
    for (int p = 0; p < 5; p++) send(8'(p + 200), 1'b0);
    for (int p = 0; p < 16; p++) send(8'(p + 70), p == 0);
    end_test("sof", 4, 1);
`endif

    // default geometry, random input gaps and random data
    start_test(1'b1, 128, 128, 0, 1'b1, 50);
    for (int p = 0; p < 128 * 128; p++) send(8'($urandom), 1'b0);
    end_test("t5", 126 * 126, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
